// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: DEPTH-word instruction RAM, NOP-cleared after reset, streaming load port (load_*), registered fetch (fetch_en/endereco -> instrucao/instr_valid/addr_error), busy in CLEAR/LOAD
module instr_mem_loadable #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD = DATA_WIDTH'({5'd17, 27'd0})
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_error,
  input  logic                  fetch_en,
  input  logic [31:0]           endereco,
  output logic [DATA_WIDTH-1:0] instrucao,
  output logic                  instr_valid,
  output logic                  addr_error,
  output logic                  busy
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  typedef enum logic [1:0] {CLEAR, READY, LOAD} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH:0] clr_ptr_q, clr_ptr_d, ld_ptr_q, ld_ptr_d;
  logic err_q, err_d, valid_q, valid_d, aerr_q, aerr_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d, wdata;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic accept, full, in_range, fetch, we;
  logic [IW-1:0] waddr;
  assign accept = state_q == LOAD && load_valid;
  assign full = ld_ptr_q == DEPTH_C;
  assign in_range = endereco < 32'(DEPTH);
  assign fetch = state_q == READY && fetch_en;
  assign we = state_q == CLEAR || (accept && !full);
  assign waddr = state_q == CLEAR ? clr_ptr_q[IW-1:0] : ld_ptr_q[IW-1:0];
  assign wdata = state_q == CLEAR ? NOP_WORD : load_data;
  always_comb begin
    state_d = state_q;
    clr_ptr_d = clr_ptr_q;
    ld_ptr_d = ld_ptr_q;
    err_d = err_q;
    if (state_q == CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == DEPTH_C - 1'b1) state_d = READY;
    end
    if (state_q == READY && load_start) begin
      state_d = LOAD;
      ld_ptr_d = '0;
      err_d = 1'b0;
    end
    if (accept) begin
      ld_ptr_d = full ? ld_ptr_q : ld_ptr_q + 1'b1;
      err_d = err_q || full;
      if (load_last) state_d = READY;
    end
    instr_d = fetch ? (in_range ? mem[endereco[IW-1:0]] : NOP_WORD)
            : (state_q == LOAD && fetch_en) ? NOP_WORD : instr_q;
    valid_d = fetch;
    aerr_d = fetch && !in_range;
  end
  always_ff @(posedge clock) if (!reset && we) mem[waddr] <= wdata;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_ptr_q <= '0;
      ld_ptr_q <= '0;
      err_q <= 1'b0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      aerr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ld_ptr_q <= ld_ptr_d;
      err_q <= err_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      aerr_q <= aerr_d;
    end
  end
  assign load_ready = state_q == LOAD;
  assign busy = state_q != READY;
  assign load_count = ld_ptr_q;
  assign load_error = err_q;
  assign instrucao = instr_q;
  assign instr_valid = valid_q;
  assign addr_error = aerr_q;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: directed bench for instr_mem_loadable with DEPTH=4
module tb_instr_mem_loadable;
  localparam int DW = 32, AW = 2, DEPTH = 4;
  localparam logic [31:0] NOP = 32'h8800_0000;
  localparam logic [31:0] W0 = 32'hC840_0004, W1 = 32'hC040_0001, W2 = 32'h9000_0000;
  logic clock = 1'b0, reset, load_start, load_valid, load_last, fetch_en;
  logic [DW-1:0] load_data, instrucao;
  logic [31:0] endereco;
  logic load_ready, load_error, instr_valid, addr_error, busy;
  logic [AW:0] load_count;
  int checks = 0, failures = 0;
  instr_mem_loadable #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .load_count(load_count), .load_error(load_error), .fetch_en(fetch_en),
    .endereco(endereco), .instrucao(instrucao), .instr_valid(instr_valid),
    .addr_error(addr_error), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input logic aerr, input string tag);
    fetch_en = 1'b1;
    endereco = a;
    tick();
    chk({tag, "_data"}, 64'(instrucao), 64'(exp));
    chk({tag, "_valid"}, 64'(instr_valid), 64'd1);
    chk({tag, "_aerr"}, 64'(addr_error), 64'(aerr));
  endtask
  task automatic push(input logic [31:0] d, input logic last);
    load_valid = 1'b1;
    load_data = d;
    load_last = last;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask
  initial begin
    reset = 1'b1; load_start = 0; load_valid = 0; load_last = 0; fetch_en = 0;
    load_data = '0; endereco = '0;
    tick();
    chk("rst_busy", 64'(busy), 64'd1);
    chk("rst_ready", 64'(load_ready), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instrucao), 64'(NOP));
    chk("rst_count", 64'(load_count), 64'd0);
    chk("rst_lerr", 64'(load_error), 64'd0);
    chk("rst_aerr", 64'(addr_error), 64'd0);
    reset = 1'b0;
    fetch_en = 1'b1;
    load_start = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("clr_busy", 64'(busy), 64'd1);
    chk("clr_nofetch", 64'(instr_valid), 64'd0);
    chk("clr_noload", 64'(load_ready), 64'd0);
    fetch_en = 1'b0;
    load_start = 1'b0;
    tick();
    chk("clr_done", 64'(busy), 64'd0);
    fetch(0, NOP, 0, "clr_f0");
    fetch(3, NOP, 0, "clr_f3");
    fetch_en = 1'b0;
    tick();
    chk("idle_valid", 64'(instr_valid), 64'd0);
    chk("idle_hold", 64'(instrucao), 64'(NOP));
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ld_ready", 64'(load_ready), 64'd1);
    chk("ld_busy", 64'(busy), 64'd1);
    chk("ld_cnt0", 64'(load_count), 64'd0);
    push(W0, 0);
    chk("ld_cnt1", 64'(load_count), 64'd1);
    fetch_en = 1'b1;
    endereco = 0;
    tick();
    fetch_en = 1'b0;
    chk("ld_fvalid", 64'(instr_valid), 64'd0);
    chk("ld_finstr", 64'(instrucao), 64'(NOP));
    chk("stall_cnt1", 64'(load_count), 64'd1);
    tick();
    chk("stall_cnt2", 64'(load_count), 64'd1);
    push(W1, 0);
    chk("bp_cnt", 64'(load_count), 64'd2);
    chk("bp_ready", 64'(load_ready), 64'd1);
    push(W2, 1);
    chk("ld_cnt3", 64'(load_count), 64'd3);
    chk("ld_done", 64'(busy), 64'd0);
    chk("ld_rdy0", 64'(load_ready), 64'd0);
    fetch(0, W0, 0, "f0");
    fetch(1, W1, 0, "f1");
    fetch(2, W2, 0, "f2");
    fetch(3, NOP, 0, "f3");
    fetch(DEPTH, NOP, 1, "bad_depth");
    fetch(32'hFFFF_FFFF, NOP, 1, "bad_max");
    fetch(1, W1, 0, "bad_after");
    load_start = 1'b1;
    fetch(2, W2, 0, "sim_fetch");
    load_start = 1'b0;
    fetch_en = 1'b0;
    chk("sim_ready", 64'(load_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      push(32'hA000_0000 + 32'(i), i == 5);
      chk($sformatf("ov_cnt%0d", i), 64'(load_count), 64'(i < 4 ? i + 1 : 4));
      chk($sformatf("ov_err%0d", i), 64'(load_error), 64'(i >= 4));
    end
    chk("ov_done", 64'(busy), 64'd0);
    for (int i = 0; i < DEPTH; i++) fetch(i, 32'hA000_0000 + 32'(i), 0, $sformatf("ov_f%0d", i));
    fetch_en = 1'b0;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ov_errclr", 64'(load_error), 64'd0);
    chk("ov_cntclr", 64'(load_count), 64'd0);
    push(32'h1111_1111, 0);
    push(32'h2222_2222, 0);
    chk("ml_cnt", 64'(load_count), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ml_ready", 64'(load_ready), 64'd0);
    chk("ml_busy", 64'(busy), 64'd1);
    chk("ml_cnt0", 64'(load_count), 64'd0);
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("ml_clr_busy", 64'(busy), 64'd1);
    tick();
    chk("ml_clr_done", 64'(busy), 64'd0);
    for (int i = 0; i < DEPTH; i++) fetch(i, NOP, 0, $sformatf("ml_f%0d", i));
    fetch_en = 1'b0;
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
